hasti_uart_loader: RTL and testbench

HASTI bus master that receives write frames on a UART RX line and performs single-word writes into the HASTI crossbar, so SRAM contents can be loaded from a host PC without re-synthesising. It sits alongside the CPU's `imem`/`dmem` masters as an extra crossbar master port and drives the initiator side of HASTI. While loading, it holds the core in reset, and it releases the core on a dedicated release frame.

---
 rtl/hasti_uart_loader_pkg.sv | 28 ++
 rtl/hasti_uart_loader_if.sv | 24 ++
 rtl/hasti_uart_loader_uart_rx.sv | 97 +++++++++
 rtl/hasti_uart_loader.sv | 173 +++++++++++++++++
 tb/tb_hasti_uart_loader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hasti_uart_loader_pkg.sv
// Constants for the HASTI UART loader.
// hasti_constants holds the HASTI bus encodings shared with the rest of the SoC.
// pk_hasti_loader holds the loader's frame constants and its frame FSM state type.
// The checksum byte and its FSM state exist only when HASTI_LOADER_CHECKSUM_EN is defined.
package hasti_constants;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
endpackage

package pk_hasti_loader;
  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
  localparam logic [31:0] RELEASE_ADDR = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
`ifdef HASTI_LOADER_CHECKSUM_EN
    ST_CSUM    = 3'd3,
`endif
    ST_ADDR_PH = 3'd4,
    ST_DATA_PH = 3'd5
  } frame_state_t;
endpackage

// File: rtl/hasti_uart_loader_if.sv
// HASTI initiator-side signal bundle with master and slave views.
interface if_hasti_master_io;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/hasti_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, LSB-first assembly.
// valid pulses for one cycle with a good byte; frame_err pulses on a low stop bit.
module uart_rx #(
  parameter int DIVISOR = 173
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  localparam int HALF = DIVISOR / 2;
  localparam int CW   = $clog2(DIVISOR + 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          rx_s1_reg, rx_s2_reg, rx_prev_reg;
  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;

  // Bring the asynchronous line into hclk and keep one older sample for edge detection.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      rx_s1_reg   <= 1'b1;
      rx_s2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_s1_reg   <= rxd;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
    end
  end

  // Bit timing: half a bit to the start-bit centre, then one full bit per sample.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_s2_reg) begin
            state_reg <= RX_START;
            cnt_reg   <= '0;
          end
        end
        RX_START: begin
          if (cnt_reg == CW'(HALF - 1)) begin
            cnt_reg   <= '0;
            bit_reg   <= 3'd0;
            // A line that is high again at mid-start was only a glitch.
            state_reg <= rx_s2_reg ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_reg == CW'(DIVISOR - 1)) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s2_reg, shift_reg[7:1]};
            if (bit_reg == 3'd7) state_reg <= RX_STOP;
            else                 bit_reg   <= bit_reg + 3'd1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          if (cnt_reg == CW'(DIVISOR - 1)) begin
            cnt_reg   <= '0;
            state_reg <= RX_IDLE;
            if (rx_s2_reg) begin
              valid <= 1'b1;
              data  <= shift_reg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/hasti_uart_loader.sv
// HASTI master that turns UART write frames into single-word bus writes and
// holds the core in reset until a release frame (addr 0xFFFF_FFFF) arrives.
// Optional checksum byte: define HASTI_LOADER_CHECKSUM_EN.
module hasti_uart_loader
  import hasti_constants::*;
  import pk_hasti_loader::*;
#(
  parameter int CLK_FREQ = 20_000_000,
  parameter int BAUD     = 115200
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               rxd,
  if_hasti_master_io.master  bus,
  output logic               core_reset,
  output logic               busy,
  output logic               err
);
  localparam int DIVISOR = CLK_FREQ / BAUD;

  logic [7:0]   rx_data;
  logic         rx_valid, rx_frame_err;
  logic         buf_full_reg;
  logic [7:0]   buf_data_reg;
  frame_state_t state_reg;
  logic [1:0]   cnt_reg;
  logic [31:0]  addr_reg, data_reg, data_next;
  logic         rx_phase, consume, overflow, bus_err, csum_err, frame_end;
  logic         unused_hrdata;

  uart_rx #(.DIVISOR(DIVISOR)) u_rx (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .rxd       (rxd),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_frame_err)
  );

  assign bus.hsize     = HSIZE_WORD;
  assign bus.hburst    = HBURST_SINGLE;
  assign bus.hmastlock = 1'b0;
  assign bus.hprot     = 4'b0011;
  assign unused_hrdata = ^bus.hrdata;

  // Bytes are only taken while collecting a frame; bus phases leave the buffer parked.
  assign rx_phase  = (state_reg != ST_ADDR_PH) && (state_reg != ST_DATA_PH);
  assign consume   = buf_full_reg && rx_phase;
  assign overflow  = rx_valid && buf_full_reg && !consume;
  assign bus_err   = (state_reg == ST_DATA_PH) && bus.hready && (bus.hresp == HRESP_ERROR);
  assign data_next = {buf_data_reg, data_reg[31:8]};

`ifdef HASTI_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
  assign frame_end = consume && (state_reg == ST_CSUM) && (buf_data_reg == csum_reg);
  assign csum_err  = consume && (state_reg == ST_CSUM) && (buf_data_reg != csum_reg);
`else
  assign frame_end = consume && (state_reg == ST_DATA) && (cnt_reg == 2'd3);
  assign csum_err  = 1'b0;
`endif

  // One-entry byte buffer; a byte landing on a full buffer is lost.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      buf_full_reg <= 1'b0;
      buf_data_reg <= 8'h00;
    end else if (rx_valid && (!buf_full_reg || consume)) begin
      buf_full_reg <= 1'b1;
      buf_data_reg <= rx_data;
    end else if (consume) begin
      buf_full_reg <= 1'b0;
    end
  end

  // Sticky error flag collecting every fault source.
  always_ff @(posedge hclk) begin
    if (!hresetn) err <= 1'b0;
    else          err <= err | rx_frame_err | overflow | bus_err | csum_err;
  end

  // Frame FSM: gather sync/addr/data bytes, then run one address + data phase.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 2'd0;
      addr_reg    <= 32'h0;
      data_reg    <= 32'h0;
      busy        <= 1'b0;
      core_reset  <= 1'b1;
      bus.htrans  <= HTRANS_IDLE;
      bus.haddr   <= 32'h0;
      bus.hwrite  <= 1'b0;
      bus.hwdata  <= 32'h0;
`ifdef HASTI_LOADER_CHECKSUM_EN
      csum_reg    <= 8'h00;
`endif
    end else if (rx_frame_err && rx_phase) begin
      // A framing error abandons a partly received frame; bus phases always finish.
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (consume && buf_data_reg == SYNC_BYTE) begin
            state_reg <= ST_ADDR;
            busy      <= 1'b1;
            cnt_reg   <= 2'd0;
`ifdef HASTI_LOADER_CHECKSUM_EN
            csum_reg  <= 8'h00;
`endif
          end
        end
        ST_ADDR: begin
          if (consume) begin
            addr_reg <= {buf_data_reg, addr_reg[31:8]};
            cnt_reg  <= cnt_reg + 2'd1;
`ifdef HASTI_LOADER_CHECKSUM_EN
            csum_reg <= csum_reg ^ buf_data_reg;
`endif
            if (cnt_reg == 2'd3) state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (consume) begin
            data_reg <= data_next;
            cnt_reg  <= cnt_reg + 2'd1;
`ifdef HASTI_LOADER_CHECKSUM_EN
            csum_reg <= csum_reg ^ buf_data_reg;
            if (cnt_reg == 2'd3) state_reg <= ST_CSUM;
`endif
          end
        end
`ifdef HASTI_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (csum_err) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
`endif
        ST_ADDR_PH: begin
          if (bus.hready) begin
            state_reg  <= ST_DATA_PH;
            bus.htrans <= HTRANS_IDLE;
            bus.hwrite <= 1'b0;
            bus.hwdata <= data_reg;
          end
        end
        ST_DATA_PH: begin
          if (bus.hready) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Completed frame: release the core, or launch the write (overrides the case).
      if (frame_end) begin
        if (addr_reg == RELEASE_ADDR) begin
          core_reset <= 1'b0;
          state_reg  <= ST_IDLE;
          busy       <= 1'b0;
        end else begin
          state_reg  <= ST_ADDR_PH;
          bus.htrans <= HTRANS_NONSEQ;
          bus.hwrite <= 1'b1;
          bus.haddr  <= {addr_reg[31:2], 2'b00};
        end
      end
    end
  end
endmodule

// File: tb/tb_hasti_uart_loader.sv
// Scoreboard bench for hasti_uart_loader: stimulus pushes expected writes,
// a bus monitor pops and compares them, and a slave model inserts wait states.
module tb_hasti_uart_loader;
  import hasti_constants::*;
  import pk_hasti_loader::*;

  localparam int CLK_FREQ = 20_000_000;
  localparam int BAUD     = 1_250_000;
  localparam int DIV      = CLK_FREQ / BAUD;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic  hclk = 1'b0;
  logic  hresetn = 1'b0;
  logic  rxd = 1'b1;
  logic  core_reset, busy, err;
  xfer_t exp_q[$];
  xfer_t mon_e;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    wait_n = 0;
  logic  resp_err = 1'b0;
  logic  aphase = 1'b0, dphase = 1'b0, mon_d = 1'b0;
  int    sl_cnt = 0;

  if_hasti_master_io bus();

  hasti_uart_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .rxd        (rxd),
    .bus        (bus),
    .core_reset (core_reset),
    .busy       (busy),
    .err        (err)
  );

  always #5 hclk = ~hclk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave model: hready chosen at negedge for the following posedge.
  initial begin
    bus.hready = 1'b1;
    bus.hresp  = HRESP_OKAY;
    bus.hrdata = 32'h0;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        aphase = 1'b0; dphase = 1'b0; bus.hready = 1'b1; bus.hresp = HRESP_OKAY;
      end else if (dphase) begin
        if (sl_cnt > 0) begin
          bus.hready = 1'b0; bus.hresp = HRESP_OKAY; sl_cnt--;
        end else begin
          bus.hready = 1'b1; bus.hresp = resp_err; dphase = 1'b0;
        end
      end else if (bus.htrans == HTRANS_NONSEQ) begin
        bus.hresp = HRESP_OKAY;
        if (!aphase) begin aphase = 1'b1; sl_cnt = wait_n; end
        if (sl_cnt > 0) begin
          bus.hready = 1'b0; sl_cnt--;
        end else begin
          bus.hready = 1'b1; aphase = 1'b0; dphase = 1'b1; sl_cnt = wait_n;
        end
      end else begin
        bus.hready = 1'b1; bus.hresp = HRESP_OKAY;
      end
    end
  end

  // Monitor: compares every address/data phase against the scoreboard head.
  initial begin
    forever begin
      @(negedge hclk);
      #1;
      if (!hresetn) begin
        mon_d = 1'b0;
      end else if (mon_d) begin
        if (exp_q.size() > 0) begin
          if (bus.hready) begin
            mon_e = exp_q.pop_front();
            chk("hwdata", bus.hwdata, mon_e.data);
            $display("xfer haddr=0x%08h hwdata=0x%08h", mon_e.addr, bus.hwdata);
          end else begin
            chk("hwdata_stall", bus.hwdata, exp_q[0].data);
          end
        end
        if (bus.hready) mon_d = 1'b0;
      end else if (bus.htrans == HTRANS_NONSEQ) begin
        if (exp_q.size() == 0) begin
          if (bus.hready) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_xfer: got haddr 0x%08h required no transfer", bus.haddr);
          end
        end else begin
          chk(bus.hready ? "haddr" : "haddr_stall", bus.haddr, exp_q[0].addr);
          if (bus.hready) chk("hwrite", {31'h0, bus.hwrite}, 32'h1);
        end
        if (bus.hready) mon_d = 1'b1;
      end
    end
  end

  task automatic uart_bit(logic v);
    rxd = v;
    repeat (DIV) @(posedge hclk);
  endtask

  task automatic send_byte(logic [7:0] b, logic stop);
    uart_bit(1'b0);
    for (int i = 0; i < 8; i++) uart_bit(b[i]);
    uart_bit(stop);
    uart_bit(1'b1);
  endtask

  task automatic send_frame(logic [31:0] a, logic [31:0] d, logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    send_byte(SYNC_BYTE, 1'b1);
    for (int i = 0; i < 4; i++) begin send_byte(a[8*i +: 8], 1'b1); x = x ^ a[8*i +: 8]; end
    for (int i = 0; i < 4; i++) begin send_byte(d[8*i +: 8], 1'b1); x = x ^ d[8*i +: 8]; end
`ifdef HASTI_LOADER_CHECKSUM_EN
    send_byte(x ^ flip, 1'b1);
`else
    if (flip != 8'h00) x = ~x;
`endif
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || bus.htrans != HTRANS_IDLE || dphase || mon_d) && n < 1000) begin
      @(posedge hclk);
      n++;
    end
    chk("idle_timeout", {31'h0, n >= 1000}, 32'h0);
    repeat (4) @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic do_reset();
    @(negedge hclk);
    hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
  endtask

  task automatic write_frame(logic [31:0] a, logic [31:0] d, logic [31:0] exp_a);
    exp_q.push_back('{addr: exp_a, data: d});
    send_frame(a, d, 8'h00);
    wait_idle();
    chk("q_empty", exp_q.size(), 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Reset state
    chk("rst_htrans", {30'h0, bus.htrans}, {30'h0, HTRANS_IDLE});
    chk("rst_haddr", bus.haddr, 32'h0);
    chk("rst_hwdata", bus.hwdata, 32'h0);
    chk("rst_hwrite", {31'h0, bus.hwrite}, 32'h0);
    chk("rst_hsize", {29'h0, bus.hsize}, 32'h2);
    chk("rst_hburst", {29'h0, bus.hburst}, 32'h0);
    chk("rst_hmastlock", {31'h0, bus.hmastlock}, 32'h0);
    chk("rst_hprot", {28'h0, bus.hprot}, 32'h3);
    chk("rst_core_reset", {31'h0, core_reset}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);

    // Single write, no wait states
    write_frame(32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1000);
    chk("single_err", {31'h0, err}, 32'h0);
    chk("single_busy", {31'h0, busy}, 32'h0);
    chk("single_core_reset", {31'h0, core_reset}, 32'h1);

    // Same frame with 3 wait states in each phase
    wait_n = 3;
    write_frame(32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1000);
    wait_n = 0;
    chk("wait_err", {31'h0, err}, 32'h0);

    // Unaligned address is forced to a word boundary
    write_frame(32'h0000_2003, 32'h1234_5678, 32'h0000_2000);

    // Noise bytes and a short glitch: no transfer, no error
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    rxd = 1'b0;
    repeat (DIV * 3 / 10) @(posedge hclk);
    rxd = 1'b1;
    repeat (DIV * 2) @(posedge hclk);
    wait_idle();
    chk("noise_err", {31'h0, err}, 32'h0);
    chk("noise_busy", {31'h0, busy}, 32'h0);
    chk("noise_q", exp_q.size(), 32'h0);

    // Framing error mid-frame: err sticks and the FSM is back in IDLE
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(8'h34, 1'b1);
    @(negedge hclk);
    chk("mid_busy", {31'h0, busy}, 32'h1);
    send_byte(8'h77, 1'b0);
    @(negedge hclk);
    chk("frame_err", {31'h0, err}, 32'h1);
    chk("frame_busy", {31'h0, busy}, 32'h0);
    write_frame(32'h0000_3000, 32'hCAFE_F00D, 32'h0000_3000);

    // Reset mid-frame abandons the partial frame
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(8'h00, 1'b1);
    do_reset();
    chk("rst2_err", {31'h0, err}, 32'h0);
    chk("rst2_busy", {31'h0, busy}, 32'h0);
    write_frame(32'h0000_4000, 32'h0BAD_C0DE, 32'h0000_4000);

    // Bus error response sets sticky err; the next frame still writes
    resp_err = 1'b1;
    write_frame(32'h0000_5000, 32'h5555_AAAA, 32'h0000_5000);
    resp_err = 1'b0;
    chk("buserr_err", {31'h0, err}, 32'h1);
    write_frame(32'h0000_5004, 32'h0000_0001, 32'h0000_5004);
    chk("buserr_sticky", {31'h0, err}, 32'h1);

    // Release frame: no transfer, core_reset drops and stays low
    do_reset();
    chk("rel_pre_core_reset", {31'h0, core_reset}, 32'h1);
    send_frame(RELEASE_ADDR, 32'h0000_0000, 8'h00);
    wait_idle();
    chk("rel_core_reset", {31'h0, core_reset}, 32'h0);
    chk("rel_q", exp_q.size(), 32'h0);
    chk("rel_err", {31'h0, err}, 32'h0);
    write_frame(32'h0000_6000, 32'hFFFF_0000, 32'h0000_6000);
    chk("post_rel_core_reset", {31'h0, core_reset}, 32'h0);

`ifdef HASTI_LOADER_CHECKSUM_EN
    // Checksum: good frame writes, corrupted checksum is dropped with err
    do_reset();
    write_frame(32'h0000_7000, 32'h0000_0001, 32'h0000_7000);
    chk("csum_ok_err", {31'h0, err}, 32'h0);
    send_frame(32'h0000_7000, 32'h0000_0001, 8'h01);
    wait_idle();
    chk("csum_bad_q", exp_q.size(), 32'h0);
    chk("csum_bad_err", {31'h0, err}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
